// File: rtl/tea_pkg.sv
// Shared definitions for the TEA byte-stream packer.
// Holds block/key widths, the packer FSM state type and a helper that
// places one byte into a 64-bit block, MSB-first by byte index.
package tea_pkg;

    localparam int BLOCK_W         = 64;
    localparam int KEY_W           = 128;
    localparam int BYTES_PER_BLOCK = 8;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ENC   = 2'd1,
        ST_DRAIN = 2'd2
    } packer_state_t;

    // Byte index 0 lands in bits [63:56], index 7 in bits [7:0].
    function automatic logic [BLOCK_W-1:0] insert_byte(
        input logic [BLOCK_W-1:0] blk,
        input logic [2:0]         idx,
        input logic [7:0]         data
    );
        logic [BLOCK_W-1:0] res;
        logic [5:0]         base;
        res            = blk;
        base           = {~idx, 3'b000};
        res[base +: 8] = data;
        return res;
    endfunction

endpackage

// File: rtl/tea_byte_serializer.sv
// 64-bit to 8-bit output serializer for ciphertext blocks.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   load                  one-cycle strobe: take load_data/load_last
//   load_data [63:0]      block to emit, bits [63:56] first
//   load_last             block is the last of its message
//   out_ready             downstream accepts a byte
//   out_data/out_valid    registered byte stream
//   out_last              registered, set on byte 8 of a last block
//   done                  byte 8 is transferring this cycle
module tea_byte_serializer
    import tea_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [BLOCK_W-1:0] load_data,
    input  logic               load_last,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    output logic               out_valid,
    output logic               out_last,
    output logic               done
);

    logic [BLOCK_W-1:0] shift_r;
    logic [2:0]         idx_r;
    logic               last_r;
    logic [7:0]         out_data_r;
    logic               out_valid_r;
    logic               out_last_r;
    logic               fire_s;

    assign fire_s    = out_valid_r & out_ready;
    assign done      = fire_s & (idx_r == 3'd7);
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;

    // Shift register and output byte/handshake state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r     <= {BLOCK_W{1'b0}};
            idx_r       <= 3'd0;
            last_r      <= 1'b0;
            out_data_r  <= 8'h00;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (load) begin
            // First byte is presented straight away; the rest waits in shift_r.
            shift_r     <= {load_data[BLOCK_W-9:0], 8'h00};
            idx_r       <= 3'd0;
            last_r      <= load_last;
            out_data_r  <= load_data[BLOCK_W-1 -: 8];
            out_valid_r <= 1'b1;
            out_last_r  <= 1'b0;
        end else if (fire_s) begin
            if (idx_r == 3'd7) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end else begin
                shift_r    <= {shift_r[BLOCK_W-9:0], 8'h00};
                idx_r      <= idx_r + 3'd1;
                out_data_r <= shift_r[BLOCK_W-1 -: 8];
                out_last_r <= last_r & (idx_r == 3'd6);
            end
        end
    end

endmodule

// File: rtl/tea_stream_packer.sv
// Byte-stream front/back end for the TEA encryption core.
// Packs input bytes into 64-bit plaintext blocks, holds plaintext and key
// stable towards the core during encryption, captures the ciphertext and
// serializes it back out MSB-first.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   in_data/in_valid/in_last/in_ready  plaintext byte stream
//   key_in/key_load                    key value and latch strobe
//   enc_ptxt/enc_key/enc_*_valid       to the core
//   enc_ctxt/enc_ctxt_ready            from the core
//   out_data/out_valid/out_last/out_ready  ciphertext byte stream
//   key_set                            a key has been latched since reset
//   err_timeout                        one-cycle pulse on encryption timeout
module tea_stream_packer
    import tea_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    input  logic [KEY_W-1:0]   key_in,
    input  logic               key_load,
    output logic [BLOCK_W-1:0] enc_ptxt,
    output logic [KEY_W-1:0]   enc_key,
    output logic               enc_ptxt_valid,
    output logic               enc_key_valid,
    input  logic [BLOCK_W-1:0] enc_ctxt,
    input  logic               enc_ctxt_ready,
    output logic [7:0]         out_data,
    output logic               out_valid,
    output logic               out_last,
    input  logic               out_ready,
    output logic               key_set,
    output logic               err_timeout
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    packer_state_t      state_r;
    packer_state_t      state_next_s;
    logic [BLOCK_W-1:0] buf_r;
    logic [2:0]         cnt_r;
    logic               block_last_r;
    logic [KEY_W-1:0]   shadow_key_r;
    logic               key_set_r;
    logic [BLOCK_W-1:0] enc_ptxt_r;
    logic [KEY_W-1:0]   enc_key_r;
    logic               enc_valid_r;
    logic [TMR_W-1:0]   timer_r;
    logic               err_timeout_r;
    logic               in_ready_r;

    logic               in_fire_s;
    logic               block_done_s;
    logic [BLOCK_W-1:0] ptxt_next_s;
    logic               key_set_next_s;
    logic               capture_s;
    logic               timeout_s;
    logic               drain_done_s;

    // in_ready_r is only ever high in FILL, so it alone qualifies a transfer.
    assign in_fire_s      = in_valid & in_ready_r;
    assign block_done_s   = in_fire_s & (in_last | (cnt_r == 3'd7));
    assign ptxt_next_s    = insert_byte(buf_r, cnt_r, in_data);
    assign key_set_next_s = key_set_r | key_load;
    assign capture_s      = (state_r == ST_ENC) & enc_ctxt_ready;
    assign timeout_s      = (state_r == ST_ENC) & ~enc_ctxt_ready
                          & (timer_r == TMR_W'(TIMEOUT_CYCLES - 1));

    assign in_ready       = in_ready_r;
    assign enc_ptxt       = enc_ptxt_r;
    assign enc_key        = enc_key_r;
    assign enc_ptxt_valid = enc_valid_r;
    assign enc_key_valid  = enc_valid_r;
    assign key_set        = key_set_r;
    assign err_timeout    = err_timeout_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_FILL: begin
                if (block_done_s) begin
                    state_next_s = ST_ENC;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_ENC: begin
                if (enc_ctxt_ready) begin
                    state_next_s = ST_DRAIN;
                end else if (timeout_s) begin
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_ENC;
                end
            end
            ST_DRAIN: begin
                if (drain_done_s) begin
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s = ST_FILL;
            end
        endcase
    end

    // Input packing buffer and byte counter; cleared as a block is handed off
    // so short blocks come out zero-padded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_r        <= {BLOCK_W{1'b0}};
            cnt_r        <= 3'd0;
            block_last_r <= 1'b0;
        end else if (block_done_s) begin
            buf_r        <= {BLOCK_W{1'b0}};
            cnt_r        <= 3'd0;
            block_last_r <= in_last;
        end else if (in_fire_s) begin
            buf_r <= ptxt_next_s;
            cnt_r <= cnt_r + 3'd1;
        end
    end

    // Shadow key; a load may arrive in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_key_r <= {KEY_W{1'b0}};
            key_set_r    <= 1'b0;
        end else if (key_load) begin
            shadow_key_r <= key_in;
            key_set_r    <= 1'b1;
        end
    end

    // Core-facing plaintext/key, frozen from FILL->ENC until the block ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_ptxt_r  <= {BLOCK_W{1'b0}};
            enc_key_r   <= {KEY_W{1'b0}};
            enc_valid_r <= 1'b0;
        end else if (block_done_s) begin
            enc_ptxt_r  <= ptxt_next_s;
            // A key strobed together with the closing byte applies to this block.
            enc_key_r   <= key_load ? key_in : shadow_key_r;
            enc_valid_r <= 1'b1;
        end else if (capture_s | timeout_s) begin
            enc_valid_r <= 1'b0;
        end
    end

    // Encryption watchdog: counts cycles spent in ENC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r       <= {TMR_W{1'b0}};
            err_timeout_r <= 1'b0;
        end else begin
            err_timeout_r <= timeout_s;
            if ((state_r == ST_ENC) && (state_next_s == ST_ENC)) begin
                timer_r <= timer_r + TMR_W'(1);
            end else begin
                timer_r <= {TMR_W{1'b0}};
            end
        end
    end

    // Input ready follows the state being entered and the key being present.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r <= 1'b0;
        end else begin
            in_ready_r <= (state_next_s == ST_FILL) & key_set_next_s;
        end
    end

    tea_byte_serializer u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (capture_s),
        .load_data (enc_ctxt),
        .load_last (block_last_r),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .done      (drain_done_s)
    );

endmodule
